// File: rtl/shift_add_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl_pkg
// Brief    : Shared definitions for the iterative shift-and-add multiplier:
//            FSM state encodings, clog2 helper, product/count width rules.
// Config   : SHIFT_ADD_MULT_EARLY_TERM_EN (used by the top module)
// Revision : 1.0 - initial release
// ============================================================================
package shift_add_mult_ctrl_pkg;

    // Controller states; encodings are fixed so they match the array-multiplier twin.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Product is always twice the operand width so the carry-out is never lost.
    function automatic int product_w(input int width);
        return 2 * width;
    endfunction

    // Step counter must be able to hold the value WIDTH itself.
    function automatic int count_w(input int width);
        return clog2(width + 1);
    endfunction

endpackage : shift_add_mult_ctrl_pkg
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl_if
// Brief    : Start/done handshake and operand/result bus of the shift-and-add
//            multiplier. master = requester, slave = multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface : shift_add_mult_ctrl_if
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl_ripple_adder
// Brief    : WIDTH-bit ripple-carry adder: half adder in bit 0, full adder
//            cells above it, carry-out exposed separately.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl_ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Carry ripples bit by bit; a single chained variable keeps the netlist a plain chain.
    always_comb begin
        logic w_c;
        sum    = '0;
        // bit 0: half adder (no carry-in)
        sum[0] = x[0] ^ y[0];
        w_c    = x[0] & y[0];
        // bits 1..WIDTH-1: full adders
        for (int i = 1; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ w_c;
            w_c    = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
        end
        cout = w_c;
    end

endmodule : shift_add_mult_ctrl_ripple_adder
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl
// Brief    : Iterative unsigned shift-and-add multiplier controller. One
//            WIDTH-bit ripple adder is reused for WIDTH cycles; start/done
//            handshake, product held until the next completion.
// Config   : SHIFT_ADD_MULT_EARLY_TERM_EN - finish as soon as the remaining
//            multiplier bits are all zero (result aligned by a barrel shift).
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_ctrl_if.slave  bus
);

    localparam int PRODUCT_W = product_w(WIDTH);
    localparam int COUNT_W   = count_w(WIDTH);
    localparam logic [COUNT_W-1:0] C_WIDTH = COUNT_W'(WIDTH);
    localparam logic [COUNT_W-1:0] C_ONE   = COUNT_W'(1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_mcand;
    logic [PRODUCT_W-1:0]   r_acc;
    logic [COUNT_W-1:0]     r_count;
    logic [PRODUCT_W-1:0]   r_product;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_ready;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic [PRODUCT_W-1:0]   w_acc_next;
    logic [COUNT_W-1:0]     w_count_next;
    logic                   w_finish;
    logic [PRODUCT_W-1:0]   w_product_next;

    // Conditional add of the multiplicand on the upper half of the accumulator.
    assign w_addend = r_acc[0] ? r_mcand : '0;

    shift_add_mult_ctrl_ripple_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (r_acc[PRODUCT_W-1:WIDTH]),
        .y    (w_addend),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Carry-out re-enters as the new MSB, so the shifted accumulator stays exact.
    assign w_acc_next   = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_count_next = r_count + C_ONE;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]   w_rem_mask;
    logic [COUNT_W-1:0] w_align;

    // Low WIDTH-count bits of the shifted accumulator are the multiplier bits not yet consumed.
    assign w_rem_mask     = {WIDTH{1'b1}} >> w_count_next;
    assign w_finish       = ((w_acc_next[WIDTH-1:0] & w_rem_mask) == '0);
    // Partial product sits WIDTH-count places too high; shift it down into place.
    assign w_align        = C_WIDTH - w_count_next;
    assign w_product_next = w_acc_next >> w_align;
`else
    // Fixed schedule: every multiplier bit is consumed before completing.
    assign w_finish       = (w_count_next == C_WIDTH);
    assign w_product_next = w_acc_next;
`endif

    // Controller FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_mcand <= bus.a;
                        r_acc   <= {{WIDTH{1'b0}}, bus.b};
                        r_count <= '0;
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= w_count_next;
                    if (w_finish) begin
                        r_product <= w_product_next;
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule : shift_add_mult_ctrl
`default_nettype wire
